// File: rtl/par_to_serial_if.sv
// rtl/par_to_serial_if.sv - word handshake in, serial stream out for par_to_serial
interface par_to_serial_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             serial_out;
  logic             active_out;
  logic             done_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, serial_out, active_out, done_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, serial_out, active_out, done_out
  );
endinterface

// File: rtl/par_to_serial.sv
// rtl/par_to_serial.sv - parallel-to-serial converter, MSB first, valid/ready load
// Define PARITY_EN to append an even-parity bit after the data bits.
module par_to_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  par_to_serial_if.slave bus
);
`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PAR = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
`ifdef PARITY_EN
  logic               par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.valid_in && ready_q) begin
          shift_d = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PARITY_EN
          par_d   = ^bus.data_in;
`endif
        end
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PARITY_EN
      PAR:  state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    serial_d = 1'b1;
    active_d = 1'b0;
    case (state_d)
      SHIFT: begin
        serial_d = shift_d[WIDTH-1];
        active_d = 1'b1;
      end
`ifdef PARITY_EN
      PAR: begin
        serial_d = par_d;
        active_d = 1'b1;
      end
`endif
      default: ;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
`ifdef PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.ready_out  = ready_q;
  assign bus.serial_out = serial_q;
  assign bus.active_out = active_q;
  assign bus.done_out   = done_q;
endmodule

// File: tb/tb_par_to_serial.sv
// tb/tb_par_to_serial.sv - directed self-checking bench for par_to_serial
module tb_par_to_serial;
  localparam int WIDTH = 8;
`ifdef PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic clk = 1'b0;
  logic reset_L;
  int   total = 0;
  int   bad = 0;

  par_to_serial_if #(.WIDTH(WIDTH)) ifc ();
  par_to_serial #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (ifc)
  );

  always #20 clk = ~clk;

  // Observed outputs packed as {serial, active, done, ready}.
  function automatic logic [3:0] obs();
    return {ifc.serial_out, ifc.active_out, ifc.done_out, ifc.ready_out};
  endfunction

  task automatic test_reset();
    reset_L = 1'b0;
    ifc.valid_in = 1'b0;
    ifc.data_in = '0;
    repeat (2) @(negedge clk);
    total++;
    if (obs() !== 4'b1001) begin
      bad++;
      $display("FAIL reset_hold got=%b want=1001", obs());
    end
    reset_L = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== 4'b1001) begin
      bad++;
      $display("FAIL reset_release got=%b want=1001", obs());
    end
  endtask

  task automatic test_single_word();
    logic [7:0] d;
    d = 8'hA5;
    @(negedge clk);
    ifc.data_in = d;
    ifc.valid_in = 1'b1;
    total++;
    if (ifc.ready_out !== 1'b1) begin
      bad++;
      $display("FAIL single_ready_before got=%b want=1", ifc.ready_out);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ifc.valid_in = 1'b0;
      total++;
      if (obs() !== {d[7-i], 3'b100}) begin
        bad++;
        $display("FAIL single_bit%0d got=%b want=%b", i, obs(), {d[7-i], 3'b100});
      end
    end
`ifdef PARITY_EN
    @(negedge clk);
    total++;
    if (obs() !== 4'b0100) begin
      bad++;
      $display("FAIL single_parity got=%b want=0100", obs());
    end
`endif
    @(negedge clk);
    total++;
    if (obs() !== 4'b1010) begin
      bad++;
      $display("FAIL single_done got=%b want=1010", obs());
    end
    @(negedge clk);
    total++;
    if (obs() !== 4'b1001) begin
      bad++;
      $display("FAIL single_idle got=%b want=1001", obs());
    end
  endtask

  task automatic test_ignored_valid();
    logic [7:0] d;
    d = 8'h3C;
    @(negedge clk);
    ifc.data_in = d;
    ifc.valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ifc.data_in = 8'hFF;
      total++;
      if (obs() !== {d[7-i], 3'b100}) begin
        bad++;
        $display("FAIL ignored_bit%0d got=%b want=%b", i, obs(), {d[7-i], 3'b100});
      end
    end
`ifdef PARITY_EN
    @(negedge clk);
    total++;
    if (obs() !== 4'b0100) begin
      bad++;
      $display("FAIL ignored_parity got=%b want=0100", obs());
    end
`endif
    @(negedge clk);
    total++;
    if (obs() !== 4'b1010) begin
      bad++;
      $display("FAIL ignored_done got=%b want=1010", obs());
    end
    @(negedge clk);
    total++;
    if (obs() !== 4'b1001) begin
      bad++;
      $display("FAIL ignored_idle got=%b want=1001", obs());
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ifc.valid_in = 1'b0;
      total++;
      if (obs() !== 4'b1100) begin
        bad++;
        $display("FAIL ignored_ff_bit%0d got=%b want=1100", i, obs());
      end
    end
`ifdef PARITY_EN
    @(negedge clk);
    total++;
    if (obs() !== 4'b0100) begin
      bad++;
      $display("FAIL ignored_ff_parity got=%b want=0100", obs());
    end
`endif
    repeat (2) @(negedge clk);
    total++;
    if (obs() !== 4'b1001) begin
      bad++;
      $display("FAIL ignored_ff_idle got=%b want=1001", obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0;
    logic [7:0] d1;
    int n;
    bit seen;
    d0 = 8'h81;
    d1 = 8'h7E;
    @(negedge clk);
    ifc.data_in = d0;
    ifc.valid_in = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n++;
      if (i == 0) ifc.data_in = d1;
      total++;
      if (obs() !== {d0[7-i], 3'b100}) begin
        bad++;
        $display("FAIL b2b_first_bit%0d got=%b want=%b", i, obs(), {d0[7-i], 3'b100});
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 3 + PBITS + 4 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (n > 8 + PBITS && ifc.active_out === 1'b1) seen = 1'b1;
    end
    ifc.valid_in = 1'b0;
    total++;
    if (!seen || n - 1 != 10 + PBITS) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=%0d seen=%0d", n - 1, 10 + PBITS, seen);
    end
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      total++;
      if (obs() !== {d1[7-i], 3'b100}) begin
        bad++;
        $display("FAIL b2b_second_bit%0d got=%b want=%b", i, obs(), {d1[7-i], 3'b100});
      end
    end
`ifdef PARITY_EN
    @(negedge clk);
`endif
    @(negedge clk);
    total++;
    if (obs() !== 4'b1010) begin
      bad++;
      $display("FAIL b2b_done got=%b want=1010", obs());
    end
    @(negedge clk);
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'h07;
    @(negedge clk);
    ifc.data_in = d;
    ifc.valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ifc.valid_in = 1'b0;
      total++;
      if (obs() !== {d[7-i], 3'b100}) begin
        bad++;
        $display("FAIL parity_bit%0d got=%b want=%b", i, obs(), {d[7-i], 3'b100});
      end
    end
    @(negedge clk);
    total++;
    if (obs() !== 4'b1100) begin
      bad++;
      $display("FAIL parity_07 got=%b want=1100", obs());
    end
    @(negedge clk);
    total++;
    if (obs() !== 4'b1010) begin
      bad++;
      $display("FAIL parity_done got=%b want=1010", obs());
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_abort();
    bit done_seen;
    @(negedge clk);
    ifc.data_in = 8'hA5;
    ifc.valid_in = 1'b1;
    @(negedge clk);
    ifc.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    #5;
    reset_L = 1'b0;
    #1;
    total++;
    if (obs() !== 4'b1001) begin
      bad++;
      $display("FAIL abort_instant got=%b want=1001", obs());
    end
    @(negedge clk);
    reset_L = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (obs() !== 4'b1001) done_seen = 1'b1;
    end
    total++;
    if (done_seen) begin
      bad++;
      $display("FAIL abort_no_replay got=%b want=1001", obs());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_ignored_valid();
    test_back_to_back();
`ifdef PARITY_EN
    test_parity();
`endif
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
